// File: rtl/guess_pkg.sv
// Shared definitions for the guessing-game round controller: state
// encoding, attempt-bar LED patterns and the "no best score yet" marker.
package guess_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

  // Attempt bar is active-low: a 0 bit lights its LED.
  localparam logic [7:0] LED_ALL_ON = 8'h00;
  localparam logic [7:0] LED_OFF    = 8'hFF;
  localparam logic [7:0] LED_LOSE   = 8'hF0;

  localparam logic [3:0] BEST_NONE  = 4'hF;

  // End-of-game display: the lit pattern during the "on" phase and after the
  // blink sequence has finished, everything dark during the "off" phase.
  function automatic logic [7:0] blink_pattern(input logic       phase,
                                               input logic       done,
                                               input logic [7:0] lit);
    return (done || phase) ? lit : LED_OFF;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// End-of-game blink sequencer: a BLINK_DIV-cycle divider that toggles the
// blink phase at each wrap and counts half-periods until 2*BLINK_NUM of
// them have elapsed, after which it freezes and reports done.
module blink_timer #(
  parameter int BLINK_DIV = 6000000,
  parameter int BLINK_NUM = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_run,
  output logic o_phase,
  output logic o_done
);

  localparam int DIV_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HALVES = 2 * BLINK_NUM;
  localparam int HC_W   = (HALVES > 0) ? $clog2(HALVES + 1) : 1;

  logic [DIV_W-1:0] r_div;
  logic [HC_W-1:0]  r_halves;
  logic             r_phase;
  logic             w_wrap;

  assign w_wrap  = (r_div == DIV_W'(BLINK_DIV - 1));
  assign o_done  = (r_halves == HC_W'(HALVES));
  assign o_phase = r_phase;

  // Divider and half-period counter; start re-arms with the phase "on".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_halves <= '0;
      r_phase  <= 1'b0;
    end else if (i_start) begin
      r_div    <= '0;
      r_halves <= '0;
      r_phase  <= 1'b1;
    end else if (i_run && !o_done) begin
      if (w_wrap) begin
        r_div    <= '0;
        r_phase  <= ~r_phase;
        r_halves <= r_halves + HC_W'(1);
      end else begin
        r_div    <= r_div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/guess_round_ctrl.sv
// Round controller behind the two-digit guessing-game core: counts guesses,
// decides win/lose, drives the active-low attempt bar (with an end-of-game
// blink) and remembers the fewest tries of any won round.
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int MAX_TRIES = 8,
  parameter int BLINK_DIV = 6000000,
  parameter int BLINK_NUM = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       res_valid,
  input  logic [1:0] res_a,
  input  logic [1:0] res_b,
  output logic [7:0] led_n,
  output logic [3:0] tries,
  output logic [3:0] best,
  output logic       win,
  output logic       lose,
  output logic       playing
);

  // One lit LED per allowed try in the low bits, the rest stay dark.
  localparam logic [7:0] BAR_FULL  = 8'(LED_OFF << MAX_TRIES);
  localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_tries;
  logic [3:0] r_best;
  logic [7:0] r_bar;
  logic [3:0] w_tries_inc;
  logic       w_guess;
  logic       w_hit;
  logic       w_blink_start;
  logic       w_blink_run;
  logic       w_phase;
  logic       w_done;

  // A guess only counts in PLAY and only if no new_game arrives with it.
  assign w_guess     = res_valid && !new_game && (r_state == ST_PLAY);
  assign w_hit       = w_guess && (res_a == 2'd2);
  assign w_tries_inc = r_tries + 4'd1;

  // Re-arm the blink on every new round and on entry to WIN or LOSE.
  assign w_blink_start = new_game || (w_guess && (w_state_nxt != ST_PLAY));
  assign w_blink_run   = (r_state == ST_WIN) || (r_state == ST_LOSE);

  blink_timer #(
    .BLINK_DIV (BLINK_DIV),
    .BLINK_NUM (BLINK_NUM)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_blink_start),
    .i_run   (w_blink_run),
    .o_phase (w_phase),
    .o_done  (w_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: new_game wins over everything; a right guess beats running out.
  always_comb begin
    w_state_nxt = r_state;
    if (new_game) begin
      w_state_nxt = ST_PLAY;
    end else if (w_guess) begin
      if (res_a == 2'd2)                w_state_nxt = ST_WIN;
      else if (w_tries_inc == TRIES_MAX) w_state_nxt = ST_LOSE;
    end
  end

  // Round bookkeeping: try counter, attempt bar and best score (rst-only clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tries <= 4'd0;
      r_bar   <= LED_OFF;
      r_best  <= BEST_NONE;
    end else if (new_game) begin
      r_tries <= 4'd0;
      r_bar   <= BAR_FULL;
    end else if (w_guess) begin
      r_tries             <= w_tries_inc;
      r_bar[r_tries[2:0]] <= 1'b1;
      if (w_hit && (w_tries_inc < r_best))
        r_best <= w_tries_inc;
    end
  end

  // Output decode from registered state, bar and blink phase.
  always_comb begin
    led_n   = LED_OFF;
    win     = 1'b0;
    lose    = 1'b0;
    playing = 1'b0;
    case (r_state)
      ST_PLAY: begin
        playing = 1'b1;
        led_n   = r_bar;
      end
      ST_WIN: begin
        win   = 1'b1;
        led_n = blink_pattern(w_phase, w_done, LED_ALL_ON);
      end
      ST_LOSE: begin
        lose  = 1'b1;
        led_n = blink_pattern(w_phase, w_done, LED_LOSE);
      end
      default: ;
    endcase
  end

  assign tries = r_tries;
  assign best  = r_best;

  // The core never reports more than two digits in total.
  a_res_sum: assert property (@(posedge clk) disable iff (rst)
    res_valid |-> (({1'b0, res_a} + {1'b0, res_b}) <= 3'd2));

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Bench for guess_round_ctrl: directed round scenarios followed by random
// guess/new_game/reset traffic, compared each cycle against a round-level
// reference model.
module tb_guess_round_ctrl;

  localparam int MAX_TRIES = 8;
  localparam int BLINK_DIV = 4;
  localparam int BLINK_NUM = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_game;
  logic       res_valid;
  logic [1:0] res_a;
  logic [1:0] res_b;
  logic [7:0] led_n;
  logic [3:0] tries;
  logic [3:0] best;
  logic       win;
  logic       lose;
  logic       playing;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  guess_round_ctrl #(
    .MAX_TRIES (MAX_TRIES),
    .BLINK_DIV (BLINK_DIV),
    .BLINK_NUM (BLINK_NUM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .new_game  (new_game),
    .res_valid (res_valid),
    .res_a     (res_a),
    .res_b     (res_b),
    .led_n     (led_n),
    .tries     (tries),
    .best      (best),
    .win       (win),
    .lose      (lose),
    .playing   (playing)
  );

  // Reference model of a round
  typedef enum {M_IDLE, M_PLAY, M_WIN, M_LOSE} mstate_e;
  mstate_e m_st;
  int      m_tries;
  int      m_best;
  bit      m_lit [MAX_TRIES];
  int      m_k;   // clock edges since the round ended

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_led();
    logic [7:0] v;
    int half;
    v = 8'hFF;
    case (m_st)
      M_PLAY: for (int i = 0; i < MAX_TRIES; i++) if (m_lit[i]) v[i] = 1'b0;
      M_WIN, M_LOSE: begin
        half = m_k / BLINK_DIV;
        if (half >= 2 * BLINK_NUM || (half % 2) == 0)
          v = (m_st == M_WIN) ? 8'h00 : 8'hF0;
      end
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_st    = M_IDLE;
    m_tries = 0;
    m_best  = 15;
    m_k     = 0;
    for (int i = 0; i < MAX_TRIES; i++) m_lit[i] = 1'b0;
  endtask

  task automatic model_step(input bit ng, input bit rv, input int a);
    if (ng) begin
      m_st    = M_PLAY;
      m_tries = 0;
      m_k     = 0;
      for (int i = 0; i < MAX_TRIES; i++) m_lit[i] = 1'b1;
    end else if (rv && m_st == M_PLAY) begin
      m_lit[m_tries] = 1'b0;
      m_tries++;
      if (a == 2) begin
        m_st = M_WIN;
        m_k  = 0;
        if (m_tries < m_best) m_best = m_tries;
      end else if (m_tries == MAX_TRIES) begin
        m_st = M_LOSE;
        m_k  = 0;
      end
    end else if (m_st == M_WIN || m_st == M_LOSE) begin
      m_k++;
    end
  endtask

  task automatic check_all();
    check_eq("led_n",   32'(led_n),   32'(exp_led()));
    check_eq("tries",   32'(tries),   32'(m_tries));
    check_eq("best",    32'(best),    32'(m_best));
    check_eq("win",     32'(win),     32'(m_st == M_WIN));
    check_eq("lose",    32'(lose),    32'(m_st == M_LOSE));
    check_eq("playing", 32'(playing), 32'(m_st == M_PLAY));
  endtask

  // Called at a falling edge; drives one clock of inputs and checks the result.
  task automatic cycle(input bit ng, input bit rv, input logic [1:0] a, input logic [1:0] b);
    a_legal_res: assert (int'(a) + int'(b) <= 2);
    new_game  = ng;
    res_valid = rv;
    res_a     = a;
    res_b     = b;
    @(posedge clk);
    model_step(ng, rv, int'(a));
    @(negedge clk);
    new_game  = 1'b0;
    res_valid = 1'b0;
    check_all();
  endtask

  task automatic guess(input logic [1:0] a);
    cycle(1'b0, 1'b1, a, 2'd0);
  endtask

  task automatic start_round();
    cycle(1'b1, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] ra;
    logic [1:0] rb;
    bit         rng;
    bit         rrv;

    rst       = 1'b1;
    new_game  = 1'b0;
    res_valid = 1'b0;
    res_a     = 2'd0;
    res_b     = 2'd0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Round start
    start_round();

    // Win on the third guess, watch the full blink and the hold
    guess(2'd0);
    guess(2'd1);
    guess(2'd2);
    idle(12);
    guess(2'd2);
    idle(16);

    // Lose after MAX_TRIES misses, then a further guess is ignored
    start_round();
    for (int i = 0; i < MAX_TRIES; i++) guess(2'd0);
    idle(26);
    guess(2'd0);

    // new_game with a simultaneous result drops the result
    start_round();
    guess(2'd0);
    guess(2'd1);
    cycle(1'b1, 1'b1, 2'd2, 2'd0);
    guess(2'd1);

    // Best score only improves
    start_round();
    guess(2'd0); guess(2'd0); guess(2'd2);
    start_round();
    for (int i = 0; i < 4; i++) guess(2'd1);
    guess(2'd2);
    start_round();
    guess(2'd0); guess(2'd2);
    idle(5);

    // Reset in the middle of a win blink, then results in IDLE are ignored
    start_round();
    guess(2'd1);
    guess(2'd2);
    idle(9);
    async_reset();
    for (int i = 0; i < 3; i++) guess(2'd2);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        rng = ($urandom_range(0, 39) == 0);
        rrv = ($urandom_range(0, 2) == 0);
        ra  = 2'($urandom_range(0, 2));
        rb  = 2'($urandom_range(0, 2 - int'(ra)));
        cycle(rng, rrv, ra, rb);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
Round controller directly downstream of the two-digit guessing-game core. It consumes the per-guess result (A = right digit and right place, B = right digit and wrong place) each time the player confirms a guess. It counts attempts and declares win or lose. It drives the active-low attempt-bar LEDs, including a timed blink on game end, and it keeps a best-score register.

Parameters:
MAX_TRIES, 8, guesses allowed per round (1..8; one bar LED per try).
BLINK_DIV, 6000000, clk cycles per blink half-period (2 Hz at 12 MHz); set small in simulation.
BLINK_NUM, 3, number of full on/off blink periods shown on game end.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
new_game  in  1  one-cycle pulse (debounced); starts or restarts a round.
res_valid  in  1  one-cycle pulse; res_a/res_b are valid this cycle.
res_a  in  2  count of right digit in right place (0..2).
res_b  in  2  count of right digit in wrong place (0..2).
led_n  out  8  attempt bar, active-low (0 = lit).
tries  out  4  guesses consumed in the current round.
best  out  4  fewest tries of any won round; 4'hF = none yet.
win  out  1  high in the WIN state.
lose  out  1  high in the LOSE state.
playing  out  1  high in the PLAY state.

Behaviour:
- Reset values (asynchronous): state IDLE, led_n 8'hFF, tries 0, best 4'hF, win 0, lose 0, playing 0, blink counters cleared.
- States: IDLE, PLAY, WIN, LOSE. All outputs are registered, so every output changes one clock after the causing input edge.
- new_game in any state:
  - next state PLAY, tries cleared to 0, blink counters cleared.
  - led_n gets bits [MAX_TRIES-1:0] = 0 (lit); upper bits stay 1.
- new_game has priority over res_valid in the same cycle. That res_valid is dropped and does not count as a guess.
- res_valid in PLAY:
  - tries increments by 1.
  - LED number tries (the pre-increment value, counting from bit 0) is extinguished: led_n[tries] set to 1.
  - If res_a == 2: next state WIN. If tries+1 < best, best is updated to tries+1.
  - Else if tries+1 == MAX_TRIES: next state LOSE.
  - Else: remain in PLAY.
- The winning guess consumes its LED, exactly as a losing guess does.
- res_valid is ignored in IDLE, WIN and LOSE.
- res_a == 3 or res_b == 3 are illegal. They are treated as an ordinary non-winning guess, and an assertion fires in the bench.
- res_b is unused by the state logic. It is carried only for a sanity assertion: res_a + res_b <= 2.
- On entry to WIN or LOSE: the divider restarts at 0 and the blink phase is set to "on".
- WIN blink:
  - phase on: led_n = 8'h00 (all lit); phase off: led_n = 8'hFF.
  - The divider counts 0..BLINK_DIV-1. At the wrap it toggles the phase and increments the half-period count.
  - After 2*BLINK_NUM half-periods, led_n is held at 8'h00 until new_game or rst.
- LOSE blink: same timing. Phase on: led_n = 8'hF0; phase off: led_n = 8'hFF. The final hold value is 8'hF0.
- win, lose and playing are one-hot decodes of state. All three are 0 in IDLE.
- tries saturates structurally, because LOSE is entered at MAX_TRIES. tries is never cleared by WIN or LOSE, only by new_game or rst.
- best survives new_game and is cleared to 4'hF only by rst.
- rst asserted mid-blink or mid-round: all outputs return to their reset values asynchronously, including best.

Decomposition:
- Shared package guess_pkg:
  - state encoding (IDLE=0, PLAY=1, WIN=2, LOSE=3);
  - LED patterns: LED_ALL_ON=8'h00, LED_OFF=8'hFF, LED_LOSE=8'hF0;
  - BEST_NONE=4'hF.
- One natural sub-module, blink_timer: BLINK_DIV divider plus half-period counter.
  - Inputs: clk, rst, start (pulse), BLINK_NUM parameter.
  - Outputs: phase, done.
  - Instantiated once; the controller muxes its output onto led_n according to state.

Test Plan:
1. rst pulse, then new_game with MAX_TRIES=8 -> playing=1, led_n=8'h00, tries=0, best=4'hF.
2. Three res_valid pulses with res_a=0,1,2 -> after the third: tries=3, win=1, best=3, led_n blinks 8'h00/8'hFF for 6 half-periods (BLINK_DIV=4, so 24 cycles), then holds 8'h00.
3. Eight res_valid pulses with res_a=0 -> lose=1 after the 8th, tries=8, led_n blinks 8'hF0/8'hFF, then holds 8'hF0; a 9th res_valid leaves tries=8.
4. new_game and res_valid in the same cycle during PLAY with tries=2 -> tries=0, led_n=8'h00, state PLAY.
5. Win in 3 tries, new_game, then win in 5 tries -> best stays 3; another round won in 2 tries -> best=2.
6. rst asserted mid-way through the WIN blink -> led_n=8'hFF, win=0, best=4'hF immediately; res_valid in IDLE afterwards -> tries stays 0.
